// File: rtl/fpu_exec_ctrl.sv
// FP execute controller: short ops answered in one cycle, long ops handed to an external unit.
// Optional watchdog on long ops is enabled by defining FPU_EXEC_CTRL_TIMEOUT_EN.
module fpu_exec_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [6:0]  alu_control,
  input  logic        fpu_reg_write,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_to_fpr,
  output logic        unit_start,
  output logic [2:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_result,
  output logic        err
);

  // state   | meaning
  // ST_IDLE | accepting ops; short ops complete here
  // ST_WAIT | long op outstanding in the external unit
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [6:0] OP_ADD    = 7'b0000000;
  localparam logic [6:0] OP_FMV    = 7'b0100001;
  localparam logic [6:0] OP_FSGNJ  = 7'b0100010;
  localparam logic [6:0] OP_FSGNJN = 7'b0100011;
  localparam logic [6:0] OP_FADD   = 7'b1000000;
  localparam logic [6:0] OP_FSUB   = 7'b1000001;
  localparam logic [6:0] OP_FMUL   = 7'b1000010;
  localparam logic [6:0] OP_FDIV   = 7'b1000011;
  localparam logic [6:0] OP_FEQ    = 7'b1000100;
  localparam logic [6:0] OP_FLT    = 7'b1000101;
  localparam logic [6:0] OP_FLE    = 7'b1000110;
  localparam logic [6:0] OP_FSQRT  = 7'b1000111;
  localparam logic [6:0] OP_FCVTWS = 7'b1001111;
  localparam logic [6:0] OP_FCVTSW = 7'b1010111;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  state_t      state;
  logic [4:0]  pend_rd;
  logic        pend_fpr;

  logic        is_long;
  logic        is_known;
  logic [2:0]  long_op;
  logic [31:0] short_res;
  logic        cmp_eq;
  logic        cmp_lt;

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signed zeros compare equal; any NaN makes every relation false.
  always_comb begin
    logic any_nan;
    logic both_zero;
    any_nan   = f_is_nan(src_a) || f_is_nan(src_b);
    both_zero = (src_a[30:0] == 31'd0) && (src_b[30:0] == 31'd0);
    cmp_eq    = !any_nan && ((src_a == src_b) || both_zero);
    cmp_lt    = 1'b0;
    if (!any_nan && !both_zero) begin
      if (src_a[31] != src_b[31])
        cmp_lt = src_a[31];
      else if (src_a[31])
        cmp_lt = src_a[30:0] > src_b[30:0];
      else
        cmp_lt = src_a[30:0] < src_b[30:0];
    end
  end

  always_comb begin
    is_long   = 1'b0;
    is_known  = 1'b1;
    long_op   = 3'b000;
    short_res = 32'd0;
    case (alu_control)
      OP_ADD:    short_res = src_a + src_b;
      OP_FMV:    short_res = src_a;
      OP_FSGNJ:  short_res = {src_b[31], src_a[30:0]};
      OP_FSGNJN: short_res = {~src_b[31], src_a[30:0]};
      OP_FEQ:    short_res = {31'd0, cmp_eq};
      OP_FLT:    short_res = {31'd0, cmp_lt};
      OP_FLE:    short_res = {31'd0, cmp_eq | cmp_lt};
      OP_FADD:   begin is_long = 1'b1; long_op = 3'b000; end
      OP_FSUB:   begin is_long = 1'b1; long_op = 3'b001; end
      OP_FMUL:   begin is_long = 1'b1; long_op = 3'b010; end
      OP_FDIV:   begin is_long = 1'b1; long_op = 3'b011; end
      OP_FSQRT:  begin is_long = 1'b1; long_op = 3'b100; end
      OP_FCVTWS: begin is_long = 1'b1; long_op = 3'b101; end
      OP_FCVTSW: begin is_long = 1'b1; long_op = 3'b110; end
      default:   is_known = 1'b0;
    endcase
  end

  assign issue_ready = (state == ST_IDLE);

`ifdef FPU_EXEC_CTRL_TIMEOUT_EN
  logic [31:0] wdog_cnt;
`else
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      result_valid  <= 1'b0;
      result        <= 32'd0;
      result_rd     <= 5'd0;
      result_to_fpr <= 1'b0;
      unit_start    <= 1'b0;
      unit_op       <= 3'b000;
      unit_a        <= 32'd0;
      unit_b        <= 32'd0;
      pend_rd       <= 5'd0;
      pend_fpr      <= 1'b0;
`ifdef FPU_EXEC_CTRL_TIMEOUT_EN
      err           <= 1'b0;
      wdog_cnt      <= 32'd0;
`endif
    end else begin
      result_valid <= 1'b0;
      unit_start   <= 1'b0;
`ifdef FPU_EXEC_CTRL_TIMEOUT_EN
      err          <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (issue_valid) begin
            if (is_long) begin
              state      <= ST_WAIT;
              unit_start <= 1'b1;
              unit_op    <= long_op;
              unit_a     <= src_a;
              unit_b     <= src_b;
              pend_rd    <= rd;
              pend_fpr   <= fpu_reg_write;
`ifdef FPU_EXEC_CTRL_TIMEOUT_EN
              wdog_cnt   <= 32'd0;
`endif
            end else begin
              result_valid  <= 1'b1;
              result        <= short_res;
              result_rd     <= is_known ? rd : 5'd0;
              result_to_fpr <= is_known & fpu_reg_write;
            end
          end
        end
        ST_WAIT: begin
          // A done coincident with our own start pulse cannot belong to this op.
          if (unit_done && !unit_start) begin
            state         <= ST_IDLE;
            result_valid  <= 1'b1;
            result        <= unit_result;
            result_rd     <= pend_rd;
            result_to_fpr <= pend_fpr;
          end
`ifdef FPU_EXEC_CTRL_TIMEOUT_EN
          else if (wdog_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state         <= ST_IDLE;
            result_valid  <= 1'b1;
            err           <= 1'b1;
            result        <= CANON_NAN;
            result_rd     <= pend_rd;
            result_to_fpr <= pend_fpr;
          end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_exec_ctrl.md
FPU_EXEC_CTRL -- requirements
Module: fpu_exec_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, watchdog limit in cycles for long ops (used only with FPU_EXEC_CTRL_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 issue_valid  in  1  decoded FP op presented.
REQ-005 issue_ready  out  1  block accepts an op this cycle.
REQ-006 alu_control  in  7  decoded op code (table in REQ-013).
REQ-007 fpu_reg_write  in  1  destination is FP register file (1) or integer file (0).
REQ-008 src_a, src_b  in  32 each  operands.
REQ-009 rd  in  5  destination register index.
REQ-010 result_valid, result, result_rd, result_to_fpr  out  1/32/5/1  writeback beat.
REQ-011 unit_start, unit_op, unit_a, unit_b  out  1/3/32/32  request to external long-latency FP unit.
REQ-012 unit_done, unit_result  in  1/32  completion from external unit; err  out  1  timeout pulse.

Function
REQ-013 Codes: ADD 0000000, FMV 0100001, FSGNJ 0100010, FSGNJN 0100011, FADD 1000000, FSUB 1000001, FMUL 1000010, FDIV 1000011, FEQ 1000100, FLT 1000101, FLE 1000110, FSQRT 1000111, FCVTWS 1001111, FCVTSW 1010111.
REQ-014 Accept = issue_valid & issue_ready; issue_ready = 1 only in state IDLE.
REQ-015 Short ops (ADD, FMV, FSGNJ, FSGNJN, FEQ, FLT, FLE, unknown): result registered; result_valid high exactly 1 cycle after accept; state stays IDLE; back-to-back accepts every cycle allowed.
REQ-016 Short results: ADD = src_a+src_b mod 2^32; FMV = src_a; FSGNJ = {src_b[31],src_a[30:0]}; FSGNJN = {~src_b[31],src_a[30:0]}; FEQ/FLT/FLE = 32-bit 0/1, IEEE single compare, +0 equals -0, any NaN operand yields 0.
REQ-017 Unknown code: result = 0, result_valid pulses, result_to_fpr forced 0 and result_rd forced 0.
REQ-018 Long ops map to unit_op: FADD 000, FSUB 001, FMUL 010, FDIV 011, FSQRT 100, FCVTWS 101, FCVTSW 110.
REQ-019 Long op accept: unit_start pulses 1 cycle (cycle after accept), unit_op/unit_a/unit_b registered and held stable until completion; rd and fpu_reg_write captured; state IDLE -> WAIT.
REQ-020 WAIT: unit_done sampled only from the cycle after unit_start; on unit_done, unit_result captured, result_valid pulses next cycle, state -> IDLE (issue_ready high that same cycle).
REQ-021 unit_done in IDLE, or coincident with unit_start, ignored.
REQ-022 result_valid is a single-cycle pulse; no backpressure on writeback.
REQ-023 States: IDLE, WAIT only (2-state FSM); no other reachable encoding.

Reset
REQ-024 rstn low: state IDLE, result_valid 0, result 0, result_rd 0, result_to_fpr 0, unit_start 0, unit_op 0, unit_a 0, unit_b 0, err 0, watchdog counter 0.
REQ-025 Reset mid-WAIT abandons the op; a later unit_done for it is ignored; no result_valid emitted.
REQ-026 issue_ready = 1 in the first cycle after rstn deasserts.

Configuration
REQ-027 Macro FPU_EXEC_CTRL_TIMEOUT_EN defined: counter clears on entering WAIT and increments each WAIT cycle; on reaching TIMEOUT_CYCLES without unit_done -> result = 32'h7FC00000, result_valid and err pulse together for 1 cycle, state -> IDLE; unit_done in the same cycle as the limit wins (normal result, no err).
REQ-028 Macro undefined: no counter, err tied 0, WAIT holds indefinitely until unit_done.

Verification
REQ-029 FSGNJN, src_a=3F800000, src_b=00000000 -> 1 cycle later result=BF800000, result_valid=1, result_to_fpr=1.
REQ-030 FEQ, src_a=80000000, src_b=00000000, fpu_reg_write=0 -> result=00000001, result_to_fpr=0; FLT with src_a=7FC00000 -> result=0.
REQ-031 FDIV rd=7, unit_done asserted 5 cycles after unit_start with unit_result=40000000 -> unit_op=011, issue_ready low throughout WAIT, result=40000000, result_rd=7 exactly 1 cycle after unit_done.
REQ-032 Three back-to-back ADDs (1+2, 3+4, 5+6) -> result_valid on 3 consecutive cycles with 3, 7, B.
REQ-033 FSQRT issued, rstn pulsed low during WAIT, stray unit_done after release -> all outputs at reset values, no result_valid.
REQ-034 With FPU_EXEC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, FMUL never done -> after 16 WAIT cycles result=7FC00000, err=1 for 1 cycle, issue_ready=1 the following cycle.
